// File: rtl/dpwm_pkg.sv
// Shared types and sanitiser/offset helpers for the multiphase DPWM.
// Helpers work on a fixed 32-bit word; callers zero-extend and truncate.
package dpwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StWait
  } dpwm_state_t;

  localparam int unsigned FnWidth = 32;
  typedef logic [FnWidth-1:0] fn_word_t;

  // Periods below 2 cannot produce a usable count sequence.
  function automatic fn_word_t clamp_min2(fn_word_t v);
    return (v < fn_word_t'(2)) ? fn_word_t'(2) : v;
  endfunction

  function automatic fn_word_t clamp_le(fn_word_t v, fn_word_t lim);
    return (v > lim) ? lim : v;
  endfunction

  // (a + b) mod p, valid when a < p and b < p; sum carried one bit wider.
  function automatic fn_word_t wrap_add(fn_word_t a, fn_word_t b, fn_word_t p);
    logic [FnWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[FnWidth-1:0];
  endfunction

endpackage

// File: rtl/dpwm_multiphase_if.sv
// Configuration handshake and gate outputs of the multiphase DPWM.
interface dpwm_multiphase_if #(
  parameter int unsigned RESOLUTION = 12,
  parameter int unsigned NUM_PHASES = 4
);
  logic                  enable;
  logic [RESOLUTION-1:0] period;
  logic [RESOLUTION-1:0] duty;
  logic [RESOLUTION-1:0] deadtime_hs;
  logic [RESOLUTION-1:0] deadtime_ls;
  logic [RESOLUTION-1:0] phase_step;
  logic                  cfg_load;
  logic                  cfg_busy;
  logic [NUM_PHASES-1:0] c_hs;
  logic [NUM_PHASES-1:0] c_ls;
  logic                  pwm_clk;

  modport master (
    output enable, period, duty, deadtime_hs, deadtime_ls, phase_step, cfg_load,
    input  cfg_busy, c_hs, c_ls, pwm_clk
  );

  modport slave (
    input  enable, period, duty, deadtime_hs, deadtime_ls, phase_step, cfg_load,
    output cfg_busy, c_hs, c_ls, pwm_clk
  );
endinterface

// File: rtl/dpwm_phase_channel.sv
// One interleaved channel: phase-shifted local count, HS/LS windows, registered gates.
module dpwm_phase_channel #(
  parameter int unsigned RESOLUTION = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RESOLUTION-1:0] cnt,
  input  logic [RESOLUTION-1:0] off,
  input  logic [RESOLUTION-1:0] p,
  input  logic [RESOLUTION-1:0] d,
  input  logic [RESOLUTION-1:0] dt_hs,
  input  logic [RESOLUTION-1:0] dt_ls,
  output logic                  hs,
  output logic                  ls
);

  logic [RESOLUTION:0] lc;
  logic [RESOLUTION:0] ls_lo;
  logic                hs_on;
  logic                ls_on;

  // Local count and window decode; LS starts at or after D so HS/LS never overlap.
  always_comb begin
    if (cnt >= off) lc = {1'b0, cnt} - {1'b0, off};
    else            lc = {1'b0, cnt} + {1'b0, p} - {1'b0, off};
    ls_lo = {1'b0, d} + {1'b0, dt_ls};
    hs_on = (lc >= {1'b0, dt_hs}) && (lc < {1'b0, d});
    ls_on = (lc >= ls_lo) && (lc < {1'b0, p});
  end

  // Registered, enable-gated gate drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs <= 1'b0;
      ls <= 1'b0;
    end else begin
      hs <= enable && hs_on;
      ls <= enable && ls_on;
    end
  end

endmodule

// File: rtl/dpwm_multiphase.sv
// N-phase interleaved DPWM: master counter, staged config with sequential offset
// computation, and a glitch-free swap of the active set at the terminal count.
module dpwm_multiphase
  import dpwm_pkg::*;
#(
  parameter int unsigned RESOLUTION = 12,
  parameter int unsigned NUM_PHASES = 4
) (
  input logic               hf_clock,
  input logic               reset,
  dpwm_multiphase_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NUM_PHASES + 1);

  typedef logic [RESOLUTION-1:0] word_t;
  typedef struct packed {
    word_t p;
    word_t d;
    word_t dt_hs;
    word_t dt_ls;
    word_t step;
  } cfg_t;

  function automatic word_t trunc(fn_word_t v);
    return word_t'(v);
  endfunction

  function automatic fn_word_t ext(word_t v);
    return fn_word_t'(v);
  endfunction

  dpwm_state_t           state_q, state_d;
  logic [IdxW-1:0]       idx_q;
  cfg_t                  cfg_in;
  cfg_t                  stg_q;
  cfg_t                  act_q;
  word_t                 stg_off_q [NUM_PHASES];
  word_t                 act_off_q [NUM_PHASES];
  word_t                 cnt_q;
  logic                  pwm_q;
  logic                  ready;
  logic                  accept;
  logic                  terminal;
  logic                  swap;
  logic [NUM_PHASES-1:0] hs;
  logic [NUM_PHASES-1:0] ls;

  assign terminal = (cnt_q == act_q.p - word_t'(1));
  assign ready    = (state_q == StWait);
  assign accept   = bus.cfg_load && (state_q == StIdle);
  assign swap     = ready && terminal;

  // Sanitise raw config inputs; only captured when a load is accepted.
  always_comb begin
    cfg_in.p     = trunc(clamp_min2(ext(bus.period)));
    cfg_in.d     = trunc(clamp_le(ext(bus.duty), ext(cfg_in.p)));
    cfg_in.dt_hs = trunc(clamp_le(ext(bus.deadtime_hs), ext(cfg_in.p)));
    cfg_in.dt_ls = trunc(clamp_le(ext(bus.deadtime_ls), ext(cfg_in.p)));
    cfg_in.step  = trunc(clamp_le(ext(bus.phase_step), ext(cfg_in.p) - fn_word_t'(1)));
  end

  // Handshake FSM next-state: capture, compute offsets, wait for period boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.cfg_load) state_d = (NUM_PHASES > 1) ? StCalc : StWait;
      StCalc:  if (idx_q == IdxW'(NUM_PHASES - 1)) state_d = StWait;
      StWait:  if (terminal) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge hf_clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Staging registers and one-offset-per-cycle sequencer.
  always_ff @(posedge hf_clock or posedge reset) begin
    if (reset) begin
      stg_q <= '0;
      idx_q <= '0;
      for (int k = 0; k < NUM_PHASES; k++) stg_off_q[k] <= '0;
    end else if (accept) begin
      stg_q <= cfg_in;
      idx_q <= IdxW'(1);
      for (int k = 0; k < NUM_PHASES; k++) stg_off_q[k] <= '0;
    end else if (state_q == StCalc) begin
      for (int k = 1; k < NUM_PHASES; k++) begin
        if (idx_q == IdxW'(k)) begin
          stg_off_q[k] <= trunc(wrap_add(ext(stg_off_q[k-1]), ext(stg_q.step), ext(stg_q.p)));
        end
      end
      idx_q <= idx_q + IdxW'(1);
    end
  end

  // Master counter and active set; swap only at terminal count once offsets are ready.
  always_ff @(posedge hf_clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      act_q.p     <= word_t'(2);
      act_q.d     <= '0;
      act_q.dt_hs <= '0;
      act_q.dt_ls <= '0;
      act_q.step  <= '0;
      for (int k = 0; k < NUM_PHASES; k++) act_off_q[k] <= '0;
    end else if (swap) begin
      cnt_q     <= '0;
      act_q     <= stg_q;
      act_off_q <= stg_off_q;
    end else begin
      cnt_q <= terminal ? '0 : cnt_q + word_t'(1);
    end
  end

  // Period-start marker, same latency as the gate outputs.
  always_ff @(posedge hf_clock or posedge reset) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= (cnt_q == '0);
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ch
    dpwm_phase_channel #(
      .RESOLUTION (RESOLUTION)
    ) u_ch (
      .clk    (hf_clock),
      .reset  (reset),
      .enable (bus.enable),
      .cnt    (cnt_q),
      .off    (act_off_q[k]),
      .p      (act_q.p),
      .d      (act_q.d),
      .dt_hs  (act_q.dt_hs),
      .dt_ls  (act_q.dt_ls),
      .hs     (hs[k]),
      .ls     (ls[k])
    );
  end

  assign bus.c_hs     = hs;
  assign bus.c_ls     = ls;
  assign bus.pwm_clk  = pwm_q;
  assign bus.cfg_busy = (state_q != StIdle);

endmodule

// File: tb/tb_dpwm_multiphase.sv
// Randomised and directed bench for dpwm_multiphase against a behavioural model.
module tb_dpwm_multiphase;

  localparam int R = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dpwm_multiphase_if #(.RESOLUTION(R), .NUM_PHASES(N)) bus ();

  dpwm_multiphase #(
    .RESOLUTION (R),
    .NUM_PHASES (N)
  ) dut (
    .hf_clock (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: active set, closed-form offsets k*step mod P, pending load.
  int   m_p = 2, m_d = 0, m_dth = 0, m_dtl = 0, m_step = 0, m_cnt = 0, m_since = 0;
  bit   m_busy = 0;
  int   s_p = 2, s_d = 0, s_dth = 0, s_dtl = 0, s_step = 0;
  logic [N-1:0] e_hs = '0;
  logic [N-1:0] e_ls = '0;
  logic e_pwm = 1'b0;
  int   mo_off, mo_lc, mo_per;
  bit   mo_acc;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_p = 2; m_d = 0; m_dth = 0; m_dtl = 0; m_step = 0; m_cnt = 0;
      m_busy = 0; m_since = 0;
      e_hs = '0; e_ls = '0; e_pwm = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        mo_off = (k * m_step) % m_p;
        mo_lc  = (m_cnt - mo_off + m_p) % m_p;
        e_hs[k] = bus.enable && (mo_lc >= m_dth) && (mo_lc < m_d);
        e_ls[k] = bus.enable && (mo_lc >= m_d + m_dtl) && (mo_lc < m_p);
      end
      e_pwm  = (m_cnt == 0);
      mo_acc = bus.cfg_load && !m_busy;
      if (m_busy && m_since >= N && m_cnt == m_p - 1) begin
        m_p = s_p; m_d = s_d; m_dth = s_dth; m_dtl = s_dtl; m_step = s_step;
        m_cnt = 0; m_busy = 0;
      end else begin
        m_cnt = (m_cnt == m_p - 1) ? 0 : m_cnt + 1;
        if (m_busy) m_since++;
      end
      if (mo_acc) begin
        mo_per = int'(bus.period);
        s_p    = (mo_per < 2) ? 2 : mo_per;
        s_d    = (int'(bus.duty) > s_p) ? s_p : int'(bus.duty);
        s_dth  = (int'(bus.deadtime_hs) > s_p) ? s_p : int'(bus.deadtime_hs);
        s_dtl  = (int'(bus.deadtime_ls) > s_p) ? s_p : int'(bus.deadtime_ls);
        s_step = (int'(bus.phase_step) > s_p - 1) ? s_p - 1 : int'(bus.phase_step);
        m_busy  = 1;
        m_since = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("c_hs", 32'(bus.c_hs), 32'(e_hs));
    check("c_ls", 32'(bus.c_ls), 32'(e_ls));
    check("pwm_clk", 32'(bus.pwm_clk), 32'(e_pwm));
    check("cfg_busy", 32'(bus.cfg_busy), 32'(m_busy));
    check("hs_ls_overlap", 32'(bus.c_hs & bus.c_ls), 32'd0);
  end

  int hs_cnt [N];
  int ls_cnt [N];
  int hs_rise [N];
  int gap;

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.cfg_busy !== 1'b0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_load(int per, int du, int dh, int dl, int st);
    bus.period      = 8'(per);
    bus.duty        = 8'(du);
    bus.deadtime_hs = 8'(dh);
    bus.deadtime_ls = 8'(dl);
    bus.phase_step  = 8'(st);
    bus.cfg_load    = 1'b1;
    @(negedge clk);
    bus.cfg_load    = 1'b0;
  endtask

  task automatic load_cfg(int per, int du, int dh, int dl, int st);
    wait_idle();
    pulse_load(per, du, dh, dl, st);
    wait_idle();
  endtask

  // Align to a pwm_clk pulse (output cycle of count 0) and profile p+1 cycles.
  task automatic measure(int p);
    int g = 0;
    logic [N-1:0] prev;
    while (bus.pwm_clk !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("pwm_seen", 32'(bus.pwm_clk), 32'd1);
    for (int k = 0; k < N; k++) begin
      hs_cnt[k] = 0; ls_cnt[k] = 0; hs_rise[k] = -1;
    end
    gap  = -1;
    prev = bus.c_hs;
    for (int i = 0; i <= p; i++) begin
      if (i > 0 && bus.pwm_clk && gap < 0) gap = i;
      if (i < p) begin
        for (int k = 0; k < N; k++) begin
          if (bus.c_hs[k]) hs_cnt[k]++;
          if (bus.c_ls[k]) ls_cnt[k]++;
          if (i > 0 && bus.c_hs[k] && !prev[k] && hs_rise[k] < 0) hs_rise[k] = i;
        end
      end
      prev = bus.c_hs;
      @(negedge clk);
    end
  endtask

  initial begin
    int g;
    int busy_n;
    logic [N-1:0] acc;

    bus.enable = 1'b1;
    bus.period = '0; bus.duty = '0; bus.deadtime_hs = '0; bus.deadtime_ls = '0;
    bus.phase_step = '0; bus.cfg_load = 1'b0;
    tick(3);
    check("rst_busy", 32'(bus.cfg_busy), 32'd0);
    check("rst_hs", 32'(bus.c_hs), 32'd0);
    check("rst_ls", 32'(bus.c_ls), 32'd0);
    rst = 1'b0;
    measure(2);
    check("default_period", 32'(gap), 32'd2);

    // Nominal four-phase configuration.
    load_cfg(100, 40, 5, 5, 25);
    measure(100);
    check("t1_hs0_cnt", 32'(hs_cnt[0]), 32'd35);
    check("t1_ls0_cnt", 32'(ls_cnt[0]), 32'd55);
    check("t1_hs3_cnt", 32'(hs_cnt[3]), 32'd35);
    check("t1_hs0_rise", 32'(hs_rise[0]), 32'd5);
    check("t1_ch1_delay", 32'((hs_rise[1] - hs_rise[0] + 100) % 100), 32'd25);
    check("t1_ch2_delay", 32'((hs_rise[2] - hs_rise[0] + 100) % 100), 32'd50);
    check("t1_ch3_delay", 32'((hs_rise[3] - hs_rise[0] + 100) % 100), 32'd75);
    check("t1_pwm_gap", 32'(gap), 32'd100);

    // Load landing at count 30, with a second load attempt while busy.
    g = 0;
    while (m_cnt != 29 && g < 300) begin
      @(negedge clk);
      g++;
    end
    pulse_load(50, 40, 5, 5, 25);
    busy_n = 0;
    g = 0;
    while (bus.cfg_busy && g < 300) begin
      busy_n++;
      if (busy_n == 5) begin
        bus.period = 8'd20;
        bus.cfg_load = 1'b1;
      end else begin
        bus.cfg_load = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    bus.cfg_load = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'd70);
    tick(3);
    check("second_load_ignored", 32'(bus.cfg_busy), 32'd0);
    measure(50);
    check("p50_gap", 32'(gap), 32'd50);
    check("p50_hs0", 32'(hs_cnt[0]), 32'd35);
    check("p50_ls0", 32'(ls_cnt[0]), 32'd5);

    // Boundaries.
    load_cfg(100, 0, 5, 5, 25);
    measure(100);
    check("duty0_hs", 32'(hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3]), 32'd0);
    load_cfg(100, 200, 0, 5, 25);
    measure(100);
    check("duty_full_hs", 32'(hs_cnt[2]), 32'd100);
    check("duty_full_ls", 32'(ls_cnt[0] + ls_cnt[1] + ls_cnt[2] + ls_cnt[3]), 32'd0);
    load_cfg(100, 40, 5, 80, 25);
    measure(100);
    check("ls_empty", 32'(ls_cnt[0] + ls_cnt[1]), 32'd0);
    check("ls_empty_hs", 32'(hs_cnt[1]), 32'd35);
    load_cfg(0, 1, 0, 0, 25);
    measure(2);
    check("period0_gap", 32'(gap), 32'd2);
    load_cfg(1, 1, 0, 0, 25);
    measure(2);
    check("period1_gap", 32'(gap), 32'd2);
    load_cfg(100, 40, 5, 5, 150);
    measure(100);
    check("step_clamp_ch1", 32'((hs_rise[1] - hs_rise[0] + 100) % 100), 32'd99);
    check("step_clamp_ch2", 32'((hs_rise[2] - hs_rise[0] + 100) % 100), 32'd98);
    check("step_clamp_ch3", 32'((hs_rise[3] - hs_rise[0] + 100) % 100), 32'd97);

    // Enable gating mid-period.
    tick(37);
    bus.enable = 1'b0;
    @(negedge clk);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      acc = acc | bus.c_hs | bus.c_ls;
      @(negedge clk);
    end
    check("enable_off", 32'(acc), 32'd0);
    bus.enable = 1'b1;
    tick(120);

    // Randomised configurations, enable toggling and stray loads.
    for (int it = 0; it < 25; it++) begin
      wait_idle();
      pulse_load(int'($urandom_range(0, 120)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                 int'($urandom_range(0, 255)));
      g = int'($urandom_range(0, 150));
      for (int c = 0; c < g; c++) begin
        bus.enable = ($urandom_range(0, 9) != 0);
        bus.period = 8'($urandom_range(0, 255));
        bus.cfg_load = ($urandom_range(0, 30) == 0);
        @(negedge clk);
      end
      bus.cfg_load = 1'b0;
      bus.enable = 1'b1;
      wait_idle();
      tick(int'($urandom_range(0, 130)));
    end

    // Reset with a pending load.
    load_cfg(100, 40, 5, 5, 25);
    tick(13);
    pulse_load(60, 20, 2, 2, 10);
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.cfg_busy), 32'd0);
    check("rst_mid_hs", 32'(bus.c_hs), 32'd0);
    check("rst_mid_ls", 32'(bus.c_ls), 32'd0);
    check("rst_mid_pwm", 32'(bus.pwm_clk), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure(2);
    check("post_rst_gap", 32'(gap), 32'd2);
    check("post_rst_hs", 32'(hs_cnt[0]), 32'd0);
    check("post_rst_ls", 32'(ls_cnt[0]), 32'd2);
    check("post_rst_busy", 32'(bus.cfg_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
